// File: rtl/l1_l2_arbiter.sv
// Arbitrates the single L2 line port between the split L1 I- and D-caches.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed D-over-I priority for alternating priority.
module l1_l2_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StDone} state_e;

  state_e            state_q, state_d;
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic [ADDR_W-1:0] l2_address_q, l2_address_d;
  logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
  logic              icache_resp_q, icache_resp_d;
  logic              dcache_resp_q, dcache_resp_d;
  logic [LINE_W-1:0] icache_rdata_q, icache_rdata_d;
  logic [LINE_W-1:0] dcache_rdata_q, dcache_rdata_d;

  logic d_req;
  logic pick_d;

  assign d_req = dcache_read | dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: D-cache granted last, 1: I-cache granted last.
  logic last_grant_q, last_grant_d;

  assign pick_d = d_req & (~icache_read | last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle) begin
      if (pick_d) begin
        last_grant_d = 1'b0;
      end else if (icache_read) begin
        last_grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d        = state_q;
    l2_read_d      = l2_read_q;
    l2_write_d     = l2_write_q;
    l2_address_d   = l2_address_q;
    l2_wdata_d     = l2_wdata_q;
    icache_rdata_d = icache_rdata_q;
    dcache_rdata_d = dcache_rdata_q;
    icache_resp_d  = 1'b0;
    dcache_resp_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d      = StServeD;
          l2_read_d    = dcache_read;
          l2_write_d   = dcache_write;
          l2_address_d = dcache_address;
          if (dcache_write) begin
            l2_wdata_d = dcache_wdata;
          end
        end else if (icache_read) begin
          state_d      = StServeI;
          l2_read_d    = 1'b1;
          l2_write_d   = 1'b0;
          l2_address_d = icache_address;
        end
      end
      StServeI: begin
        if (l2_resp) begin
          state_d        = StDone;
          l2_read_d      = 1'b0;
          icache_rdata_d = l2_rdata;
          icache_resp_d  = 1'b1;
        end
      end
      StServeD: begin
        if (l2_resp) begin
          state_d       = StDone;
          l2_read_d     = 1'b0;
          l2_write_d    = 1'b0;
          dcache_resp_d = 1'b1;
          // Writebacks return no data; keep the last read line.
          if (l2_read_q) begin
            dcache_rdata_d = l2_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      l2_read_q      <= 1'b0;
      l2_write_q     <= 1'b0;
      l2_address_q   <= '0;
      l2_wdata_q     <= '0;
      icache_resp_q  <= 1'b0;
      dcache_resp_q  <= 1'b0;
      icache_rdata_q <= '0;
      dcache_rdata_q <= '0;
    end else begin
      state_q        <= state_d;
      l2_read_q      <= l2_read_d;
      l2_write_q     <= l2_write_d;
      l2_address_q   <= l2_address_d;
      l2_wdata_q     <= l2_wdata_d;
      icache_resp_q  <= icache_resp_d;
      dcache_resp_q  <= dcache_resp_d;
      icache_rdata_q <= icache_rdata_d;
      dcache_rdata_q <= dcache_rdata_d;
    end
  end

  assign l2_read      = l2_read_q;
  assign l2_write     = l2_write_q;
  assign l2_address   = l2_address_q;
  assign l2_wdata     = l2_wdata_q;
  assign icache_resp  = icache_resp_q;
  assign dcache_resp  = dcache_resp_q;
  assign icache_rdata = icache_rdata_q;
  assign dcache_rdata = dcache_rdata_q;

endmodule
